// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar scan sequencer.
// Holds the FSM state and scan-mode enums plus default widths.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } state_e;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_SWEEP    = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_e;

  localparam int DEF_ANGLE_WIDTH  = 8;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_TOF_WIDTH    = 24;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The reserved encoding behaves as static.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_SWEEP;
      2'd2:    return MODE_PINGPONG;
      default: return MODE_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/sonar_scan_sequencer_echo_detector.sv
// Echo qualifier: sample magnitude, strict threshold compare and a
// consecutive-hit run counter. hit_out fires on the sample that completes the run.
module echo_detector
  import sonar_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int HIT_COUNT    = 3
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           clear_in,
  input  logic                           valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic        [SAMPLE_WIDTH-2:0] threshold_in,
  output logic                           hit_out
);

  localparam int RUN_W = $clog2(HIT_COUNT + 1);

  logic [SAMPLE_WIDTH-2:0] mag;
  logic                    above;
  logic [RUN_W-1:0]        run_q, run_d;

  // Negating the low bits alone gives |x| for every negative value except
  // the most-negative one, which has to saturate.
  always_comb begin
    mag = sample_in[SAMPLE_WIDTH-2:0];
    if (sample_in[SAMPLE_WIDTH-1]) begin
      if (sample_in[SAMPLE_WIDTH-2:0] == '0) mag = '1;
      else mag = ~sample_in[SAMPLE_WIDTH-2:0] + (SAMPLE_WIDTH-1)'(1);
    end
  end

  assign above   = valid_in && (mag > threshold_in);
  assign hit_out = above && (run_q >= RUN_W'(HIT_COUNT - 1));

  always_comb begin
    run_d = run_q;
    if (clear_in) run_d = '0;
    else if (valid_in) begin
      if (!above) run_d = '0;
      else if (run_q != RUN_W'(HIT_COUNT)) run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) run_q <= '0;
    else run_q <= run_d;
  end

endmodule

// File: rtl/sonar_scan_sequencer.sv
// Multi-angle sonar ping sequencer: burst, blanking, listen, report per angle.
// states: IDLE wait enable | BURST tx gate | BLANK ringing ignored | LISTEN echo search | REPORT hold record
module sonar_scan_sequencer
  import sonar_pkg::*;
#(
  parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int TOF_WIDTH     = DEF_TOF_WIDTH,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 50000,
  parameter int LISTEN_CYCLES = 16252928,
  parameter int HIT_COUNT     = 3
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           enable_in,
  input  logic [1:0]                     mode_in,
  input  logic signed [ANGLE_WIDTH-1:0]  static_angle_in,
  input  logic [SAMPLE_WIDTH-2:0]        threshold_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid_in,
  output logic signed [ANGLE_WIDTH-1:0]  beam_angle_out,
  output logic                           tx_active_out,
  output logic                           burst_start_out,
  output logic                           listen_active_out,
  output logic                           result_valid_out,
  input  logic                           result_ready_in,
  output logic signed [ANGLE_WIDTH-1:0]  result_angle_out,
  output logic                           result_hit_out,
  output logic [TOF_WIDTH-1:0]           result_tof_out,
  output logic                           scan_done_out
);

  localparam int AW1     = ANGLE_WIDTH + 1;
  localparam int TIMER_W = $clog2(max3(BURST_CYCLES, BLANK_CYCLES, LISTEN_CYCLES) + 1);

  localparam logic signed [AW1-1:0]         A_MIN   = AW1'(ANGLE_MIN);
  localparam logic signed [AW1-1:0]         A_MAX   = AW1'(ANGLE_MAX);
  localparam logic signed [AW1-1:0]         A_STEP  = AW1'(ANGLE_STEP);
  localparam logic signed [ANGLE_WIDTH-1:0] ANG_MIN = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] ANG_MAX = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic [TIMER_W-1:0] T_BURST  = TIMER_W'(BURST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_BLANK  = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_LISTEN = TIMER_W'(LISTEN_CYCLES - 1);

  state_e                        state_q, state_d;
  mode_e                         mode_q, mode_d;
  logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                          dir_down_q, dir_down_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic [TOF_WIDTH-1:0]          tof_q, tof_d, tof_inc;
  logic                          burst_start_q, burst_start_d;
  logic signed [ANGLE_WIDTH-1:0] res_angle_q, res_angle_d;
  logic                          res_hit_q, res_hit_d;
  logic [TOF_WIDTH-1:0]          res_tof_q, res_tof_d;

  logic signed [AW1-1:0]         angle_x, angle_up, angle_dn;
  logic signed [ANGLE_WIDTH-1:0] angle_next;
  logic                          dir_next, endpoint;
  logic                          handshake, det_hit;
  mode_e                         start_mode;

  echo_detector #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .HIT_COUNT   (HIT_COUNT)
  ) u_echo (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .clear_in    (state_q != ST_LISTEN),
    .valid_in    (sample_valid_in && (state_q == ST_LISTEN)),
    .sample_in   (sample_in),
    .threshold_in(threshold_in),
    .hit_out     (det_hit)
  );

  // One extra bit keeps the endpoint overflow test exact.
  assign angle_x    = {angle_q[ANGLE_WIDTH-1], angle_q};
  assign angle_up   = angle_x + A_STEP;
  assign angle_dn   = angle_x - A_STEP;
  assign tof_inc    = (&tof_q) ? tof_q : tof_q + TOF_WIDTH'(1);
  assign handshake  = (state_q == ST_REPORT) && result_ready_in;
  assign start_mode = decode_mode(mode_in);

  always_comb begin
    angle_next = static_angle_in;
    dir_next   = dir_down_q;
    endpoint   = 1'b1;
    case (mode_q)
      MODE_SWEEP: begin
        endpoint = (angle_up > A_MAX);
        angle_next = endpoint ? ANG_MIN : angle_up[ANGLE_WIDTH-1:0];
      end
      MODE_PINGPONG: begin
        endpoint = (angle_q == ANG_MIN) || (angle_q == ANG_MAX);
        if (!dir_down_q) begin
          if (angle_up > A_MAX) begin
            dir_next   = 1'b1;
            angle_next = angle_dn[ANGLE_WIDTH-1:0];
          end else angle_next = angle_up[ANGLE_WIDTH-1:0];
        end else begin
          if (angle_dn < A_MIN) begin
            dir_next   = 1'b0;
            angle_next = angle_up[ANGLE_WIDTH-1:0];
          end else angle_next = angle_dn[ANGLE_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    angle_d       = angle_q;
    dir_down_d    = dir_down_q;
    timer_d       = timer_q;
    tof_d         = tof_q;
    burst_start_d = 1'b0;
    res_angle_d   = res_angle_q;
    res_hit_d     = res_hit_q;
    res_tof_d     = res_tof_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d       = ST_BURST;
          mode_d        = start_mode;
          angle_d       = (start_mode == MODE_STATIC) ? static_angle_in : ANG_MIN;
          timer_d       = T_BURST;
          tof_d         = '0;
          burst_start_d = 1'b1;
        end
      end
      ST_BURST: begin
        tof_d   = tof_inc;
        timer_d = timer_q - TIMER_W'(1);
        if (timer_q == '0) begin
          if (BLANK_CYCLES == 0) begin
            state_d = ST_LISTEN;
            timer_d = T_LISTEN;
          end else begin
            state_d = ST_BLANK;
            timer_d = T_BLANK;
          end
        end
      end
      ST_BLANK: begin
        tof_d   = tof_inc;
        timer_d = timer_q - TIMER_W'(1);
        if (timer_q == '0) begin
          state_d = ST_LISTEN;
          timer_d = T_LISTEN;
        end
      end
      ST_LISTEN: begin
        tof_d       = tof_inc;
        timer_d     = timer_q - TIMER_W'(1);
        res_angle_d = angle_q;
        if (det_hit) begin
          state_d   = ST_REPORT;
          res_hit_d = 1'b1;
          res_tof_d = tof_q;
        end else if (timer_q == '0) begin
          state_d   = ST_REPORT;
          res_hit_d = 1'b0;
          res_tof_d = '0;
        end
      end
      ST_REPORT: begin
        if (handshake) begin
          angle_d    = angle_next;
          dir_down_d = dir_next;
          if (enable_in) begin
            state_d       = ST_BURST;
            timer_d       = T_BURST;
            tof_d         = '0;
            burst_start_d = 1'b1;
          end else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_STATIC;
      angle_q       <= ANG_MIN;
      dir_down_q    <= 1'b0;
      timer_q       <= '0;
      tof_q         <= '0;
      burst_start_q <= 1'b0;
      res_angle_q   <= '0;
      res_hit_q     <= 1'b0;
      res_tof_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      angle_q       <= angle_d;
      dir_down_q    <= dir_down_d;
      timer_q       <= timer_d;
      tof_q         <= tof_d;
      burst_start_q <= burst_start_d;
      res_angle_q   <= res_angle_d;
      res_hit_q     <= res_hit_d;
      res_tof_q     <= res_tof_d;
    end
  end

  assign beam_angle_out    = angle_q;
  assign tx_active_out     = (state_q == ST_BURST);
  assign burst_start_out   = burst_start_q;
  assign listen_active_out = (state_q == ST_LISTEN);
  assign result_valid_out  = (state_q == ST_REPORT);
  assign result_angle_out  = res_angle_q;
  assign result_hit_out    = res_hit_q;
  assign result_tof_out    = res_tof_q;
  assign scan_done_out     = handshake && endpoint;

endmodule

// File: doc/sonar_scan_sequencer.md
Name: sonar_scan_sequencer

Overview:
Parametrised successor to the fixed single-angle ping loop. It sequences repeated sonar pings across a programmable set of beam angles: burst, blanking, listen, report. For each ping it drives the steering angle, the transmit gate and the one-cycle burst-start pulse to the transmit and receive beamformers. It detects the echo on the aggregated receive waveform with magnitude, threshold and consecutive-hit qualification. It emits one {angle, hit, time-of-flight} record per ping over a valid/ready handshake to downstream display and velocity logic.

Parameters:
ANGLE_WIDTH, 8, signed beam angle width in degrees
ANGLE_MIN, -30, first and lowest sweep angle
ANGLE_MAX, 30, highest sweep angle
ANGLE_STEP, 10, sweep increment, positive
SAMPLE_WIDTH, 16, signed aggregated-waveform sample width
TOF_WIDTH, 24, time-of-flight counter width
BURST_CYCLES, 524288, transmit gate duration in cycles
BLANK_CYCLES, 50000, post-burst cycles during which samples are ignored (transducer ringing)
LISTEN_CYCLES, 16252928, maximum listen window in cycles
HIT_COUNT, 3, consecutive above-threshold valid samples needed to declare an echo

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
enable_in  input  1  run pings while high
mode_in  input  2  0 static, 1 sweep-wrap, 2 ping-pong, 3 reserved (treated as static)
static_angle_in  input  ANGLE_WIDTH  angle used in static mode
threshold_in  input  SAMPLE_WIDTH-1  unsigned magnitude threshold
sample_in  input  SAMPLE_WIDTH  signed aggregated waveform
sample_valid_in  input  1  sample strobe
beam_angle_out  output  ANGLE_WIDTH  current steering angle, signed
tx_active_out  output  1  high during BURST
burst_start_out  output  1  one-cycle pulse on BURST entry
listen_active_out  output  1  high during LISTEN
result_valid_out  output  1  record available
result_ready_in  input  1  record consumed
result_angle_out  output  ANGLE_WIDTH  angle of this ping
result_hit_out  output  1  echo detected
result_tof_out  output  TOF_WIDTH  cycles from BURST entry to qualifying sample; 0 if no hit
scan_done_out  output  1  one-cycle pulse when a sweep endpoint is completed

Behaviour:
- Reset: state IDLE; all outputs 0. beam_angle_out = ANGLE_MIN. Direction = up.
- States: IDLE, BURST, BLANK, LISTEN, REPORT.
- IDLE -> BURST when enable_in=1.
  - mode_in latched on this transition; later mode_in changes are ignored until the next return to IDLE.
  - Starting angle: ANGLE_MIN in sweep and ping-pong; static_angle_in in static.
- BURST:
  - burst_start_out=1 on the entry cycle only.
  - tof counter cleared to 0 on entry, then +1 per cycle, saturating at all-ones.
  - Stays for exactly BURST_CYCLES cycles, then -> BLANK.
- BLANK: exactly BLANK_CYCLES cycles, samples ignored, then -> LISTEN. BLANK_CYCLES=0 skips straight to LISTEN.
- LISTEN:
  - Magnitude = |sample_in|; the most-negative sample saturates to the maximum positive value.
  - Valid sample with magnitude > threshold_in (strict): run count +1. Valid sample at or below threshold: run count reset to 0. Cycles without a valid sample leave the run count unchanged.
  - When the run count reaches HIT_COUNT: hit=1, tof = counter value on that cycle, -> REPORT next cycle.
  - Otherwise -> REPORT with hit=0, tof=0 after LISTEN_CYCLES cycles.
  - Run count is cleared on LISTEN entry.
- REPORT:
  - result_valid_out=1; result fields stay stable until result_ready_in=1 in the same cycle.
  - On the handshake, the angle advances per the latched mode:
    - static: re-read static_angle_in; scan_done_out pulses.
    - sweep: angle + ANGLE_STEP. If that exceeds ANGLE_MAX, wrap to ANGLE_MIN and pulse scan_done_out.
    - ping-pong: step in the current direction. If the step would pass an endpoint, reverse direction and step the other way. scan_done_out pulses on the handshake in which the reported angle equals ANGLE_MIN or ANGLE_MAX.
  - Next state after the handshake: BURST if enable_in=1, else IDLE.
- enable_in falling mid-ping: the ping completes through REPORT, then -> IDLE. Angle state is retained; it resets only on rst_n_in.
- Angle arithmetic uses ANGLE_WIDTH+1 bits so the overflow test is exact.
- Asynchronous reset mid-ping: immediate IDLE; tx_active_out drops with no clock edge needed.

Decomposition:
- Package sonar_pkg: state enum, mode enum (MODE_STATIC, MODE_SWEEP, MODE_PINGPONG), shared width constants.
- Sub-module echo_detector: magnitude, threshold compare, consecutive-run counter. Ports: clear, valid, sample, threshold, hit pulse.

Test Plan:
Bench parameters: BURST=8, BLANK=4, LISTEN=64, HIT_COUNT=2, threshold=100.
1. Static, angle 0, valid samples of 150 every cycle from LISTEN entry -> tx_active_out high for exactly 8 cycles; hit=1; tof=13 (8 burst + 4 blank + 2nd sample at index 1).
2. Sweep-wrap, no echo -> result angles -30,-20,-10,0,10,20,30,-30; each with hit=0, tof=0; scan_done_out pulses on the handshake for 30.
3. Ping-pong -> result angles -30,…,30,20,…,-30,-20; scan_done_out pulses at 30 and at -30.
4. Samples 150, 50, 150, 150; plus -32768 during BLANK -> blank sample ignored; alternating run resets; hit declared on the 4th sample; sample -32768 in LISTEN counts as above threshold.
5. result_ready_in held low 20 cycles -> result fields stable throughout; no new burst_start_out until the handshake.
6. Deassert enable_in during BURST -> that ping reports, then IDLE. Assert rst_n_in low mid-LISTEN -> all outputs 0 asynchronously; after release, first ping uses ANGLE_MIN.
